// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer and instruction pointer for the CPU core.
// Moore stage strobes are registered from the next state, so each one lines up with its state.
module cpu_sequencer #(
    parameter int unsigned PC_WIDTH                   = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR       = {PC_WIDTH{1'b0}},
    parameter int unsigned PC_STEP                    = 1,
    parameter int unsigned CNT_WIDTH                  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_ready,
    input  logic                 mem_ready,
    input  logic                 dec_mem_load,
    input  logic                 dec_mem_store,
    input  logic                 dec_reg_store,
    input  logic                 dec_halt,
    input  logic                 branch_taken,
    input  logic                 branch_absolute,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 run,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 do_fetch,
    output logic                 do_register_load,
    output logic                 do_alu_operation,
    output logic                 do_memory_fetch,
    output logic                 do_memory_store,
    output logic                 do_register_store,
    output logic                 do_next,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_REG_LOAD  = 3'd1,
        S_ALU       = 3'd2,
        S_MEM_FETCH = 3'd3,
        S_MEM_STORE = 3'd4,
        S_REG_STORE = 3'd5,
        S_NEXT      = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_STEP_W  = PC_WIDTH'(PC_STEP);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [6:0]           STRB_FETCH = 7'b1000000;

    state_t                state_q, state_d;
    logic                  mem_load_q, mem_load_d;
    logic                  mem_store_q, mem_store_d;
    logic                  reg_store_q, reg_store_d;
    logic                  halt_q, halt_d;
    logic                  br_taken_q, br_taken_d;
    logic                  br_abs_q, br_abs_d;
    logic [PC_WIDTH-1:0]   br_target_q, br_target_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [6:0]            strobe_q, strobe_d;
    logic                  halted_q, halted_d;

    // Strobe order: fetch, reg load, alu, mem fetch, mem store, reg store, next.
    function automatic logic [6:0] decode_strobes(input state_t s);
        logic [6:0] v;
        case (s)
            S_FETCH:     v = 7'b1000000;
            S_REG_LOAD:  v = 7'b0100000;
            S_ALU:       v = 7'b0010000;
            S_MEM_FETCH: v = 7'b0001000;
            S_MEM_STORE: v = 7'b0000100;
            S_REG_STORE: v = 7'b0000010;
            S_NEXT:      v = 7'b0000001;
            S_HALT:      v = 7'b0000000;
            default:     v = 7'b0000000;
        endcase
        return v;
    endfunction

    // Next-state, operand latching and retire-time PC/counter update.
    always_comb begin
        state_d     = state_q;
        mem_load_d  = mem_load_q;
        mem_store_d = mem_store_q;
        reg_store_d = reg_store_q;
        halt_d      = halt_q;
        br_taken_d  = br_taken_q;
        br_abs_d    = br_abs_q;
        br_target_d = br_target_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_ready) begin
                    state_d = S_REG_LOAD;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_REG_LOAD: begin
                mem_load_d  = dec_mem_load;
                mem_store_d = dec_mem_store;
                reg_store_d = dec_reg_store;
                halt_d      = dec_halt;
                state_d     = S_ALU;
            end
            S_ALU: begin
                br_taken_d  = branch_taken;
                br_abs_d    = branch_absolute;
                br_target_d = branch_target;
                if (mem_load_q) begin
                    state_d = S_MEM_FETCH;
                end else if (mem_store_q) begin
                    state_d = S_MEM_STORE;
                end else if (reg_store_q) begin
                    state_d = S_REG_STORE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_MEM_FETCH: begin
                // A latched store after a load makes this a read-modify-write.
                if (!mem_ready) begin
                    state_d = S_MEM_FETCH;
                end else if (mem_store_q) begin
                    state_d = S_MEM_STORE;
                end else if (reg_store_q) begin
                    state_d = S_REG_STORE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_MEM_STORE: begin
                if (!mem_ready) begin
                    state_d = S_MEM_STORE;
                end else if (reg_store_q) begin
                    state_d = S_REG_STORE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_REG_STORE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                // Relative offsets share the PC width, so a plain add wraps correctly.
                if (br_taken_q && br_abs_q) begin
                    pc_d = br_target_q;
                end else if (br_taken_q) begin
                    pc_d = pc_q + br_target_q;
                end else begin
                    pc_d = pc_q + PC_STEP_W;
                end
                cnt_d = cnt_q + CNT_ONE;
                if (halt_q) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        strobe_d = decode_strobes(state_d);
        halted_d = (state_d == S_HALT);
    end

    // State, latches, PC, counter and registered strobes; reset abandons any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            reg_store_q <= 1'b0;
            halt_q      <= 1'b0;
            br_taken_q  <= 1'b0;
            br_abs_q    <= 1'b0;
            br_target_q <= {PC_WIDTH{1'b0}};
            pc_q        <= RESET_VECTOR;
            cnt_q       <= {CNT_WIDTH{1'b0}};
            strobe_q    <= STRB_FETCH;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_load_q  <= mem_load_d;
            mem_store_q <= mem_store_d;
            reg_store_q <= reg_store_d;
            halt_q      <= halt_d;
            br_taken_q  <= br_taken_d;
            br_abs_q    <= br_abs_d;
            br_target_q <= br_target_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            halted_q    <= halted_d;
        end
    end

    assign pc                = pc_q;
    assign retired_count     = cnt_q;
    assign halted            = halted_q;
    assign do_fetch          = strobe_q[6];
    assign do_register_load  = strobe_q[5];
    assign do_alu_operation  = strobe_q[4];
    assign do_memory_fetch   = strobe_q[3];
    assign do_memory_store   = strobe_q[2];
    assign do_register_store = strobe_q[1];
    assign do_next           = strobe_q[0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed table-driven bench for cpu_sequencer: one record per clock cycle,
// followed by hand-written latency checks for multi-cycle instructions.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        mem_ready = 1'b0;
    logic        dec_mem_load = 1'b0;
    logic        dec_mem_store = 1'b0;
    logic        dec_reg_store = 1'b0;
    logic        dec_halt = 1'b0;
    logic        branch_taken = 1'b0;
    logic        branch_absolute = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        run = 1'b0;
    logic [15:0] pc;
    logic        do_fetch, do_register_load, do_alu_operation, do_memory_fetch;
    logic        do_memory_store, do_register_store, do_next, halted;
    logic [31:0] retired_count;

    int checks = 0;
    int failures = 0;

    cpu_sequencer #(
        .PC_WIDTH(16), .RESET_VECTOR(16'h0000), .PC_STEP(1), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .mem_ready(mem_ready),
        .dec_mem_load(dec_mem_load), .dec_mem_store(dec_mem_store),
        .dec_reg_store(dec_reg_store), .dec_halt(dec_halt),
        .branch_taken(branch_taken), .branch_absolute(branch_absolute),
        .branch_target(branch_target), .run(run), .pc(pc),
        .do_fetch(do_fetch), .do_register_load(do_register_load),
        .do_alu_operation(do_alu_operation), .do_memory_fetch(do_memory_fetch),
        .do_memory_store(do_memory_store), .do_register_store(do_register_store),
        .do_next(do_next), .halted(halted), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Input flag masks: {rst, fr, mr, ld, st, rs, hl, bt, ba, run}
    localparam logic [9:0] R   = 10'b1000000000;
    localparam logic [9:0] FR  = 10'b0100000000;
    localparam logic [9:0] MR  = 10'b0010000000;
    localparam logic [9:0] LD  = 10'b0001000000;
    localparam logic [9:0] ST  = 10'b0000100000;
    localparam logic [9:0] RS  = 10'b0000010000;
    localparam logic [9:0] HL  = 10'b0000001000;
    localparam logic [9:0] BT  = 10'b0000000100;
    localparam logic [9:0] BA  = 10'b0000000010;
    localparam logic [9:0] RUN = 10'b0000000001;
    localparam logic [9:0] NO  = 10'b0000000000;

    // Strobes: {fetch, reg_load, alu, mem_fetch, mem_store, reg_store, next}
    localparam logic [6:0] F_  = 7'b1000000;
    localparam logic [6:0] RL_ = 7'b0100000;
    localparam logic [6:0] AL_ = 7'b0010000;
    localparam logic [6:0] MF_ = 7'b0001000;
    localparam logic [6:0] MS_ = 7'b0000100;
    localparam logic [6:0] RS_ = 7'b0000010;
    localparam logic [6:0] NX_ = 7'b0000001;
    localparam logic [6:0] NONE_ = 7'b0000000;

    typedef struct {
        logic [9:0]  flags;
        logic [15:0] tgt;
        logic [6:0]  exp_strb;
        logic        exp_halt;
        logic [15:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [9:0] f, input logic [15:0] t, input logic [6:0] s,
                       input logic h, input logic [15:0] p, input logic [31:0] c);
        vec_t v;
        v.flags = f; v.tgt = t; v.exp_strb = s; v.exp_halt = h; v.exp_pc = p; v.exp_cnt = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {do_fetch, do_register_load, do_alu_operation, do_memory_fetch,
                do_memory_store, do_register_store, do_next};
    endfunction

    task automatic drive(input logic [9:0] f, input logic [15:0] t);
        reset = f[9]; fetch_ready = f[8]; mem_ready = f[7];
        dec_mem_load = f[6]; dec_mem_store = f[5]; dec_reg_store = f[4]; dec_halt = f[3];
        branch_taken = f[2]; branch_absolute = f[1]; run = f[0]; branch_target = t;
    endtask

    // Runs one instruction from FETCH and checks its length and retire effects.
    task automatic run_instr(input logic ld, input logic st, input logic rs, input int waits,
                             input logic [15:0] exp_pc, input logic [31:0] exp_cnt);
        int cycles = 0;
        int wcnt = 0;
        int exp_cycles;
        bit done = 1'b0;
        exp_cycles = 4 + int'(ld) + int'(st) + int'(rs) + waits;
        dec_mem_load = ld; dec_mem_store = st; dec_reg_store = rs; fetch_ready = 1'b1;
        while (!done) begin
            if ((do_memory_fetch || do_memory_store) && wcnt < waits) begin
                mem_ready = 1'b0;
                wcnt++;
            end else begin
                mem_ready = 1'b1;
            end
            @(posedge clk); #1;
            cycles++;
            if (do_fetch || cycles >= 40) done = 1'b1;
        end
        chk($sformatf("instr_len_%0d%0d%0d_w%0d", ld, st, rs, waits), cycles, exp_cycles);
        chk("instr_pc", {16'h0000, pc}, {16'h0000, exp_pc});
        chk("instr_cnt", retired_count, exp_cnt);
        dec_mem_load = 1'b0; dec_mem_store = 1'b0; dec_reg_store = 1'b0;
    endtask

    initial begin
        // Reset, then two plain instructions
        add(R,  16'h0, F_,  1'b0, 16'h0000, 32'd0);
        add(FR, 16'h0, RL_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, AL_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, NX_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, F_,  1'b0, 16'h0001, 32'd1);
        add(FR, 16'h0, RL_, 1'b0, 16'h0001, 32'd1);
        add(NO, 16'h0, AL_, 1'b0, 16'h0001, 32'd1);
        add(NO, 16'h0, NX_, 1'b0, 16'h0001, 32'd1);
        add(NO, 16'h0, F_,  1'b0, 16'h0002, 32'd2);
        // FETCH waits; run and mem_ready ignored there
        add(NO,       16'h0, F_,  1'b0, 16'h0002, 32'd2);
        add(MR | RUN, 16'h0, F_,  1'b0, 16'h0002, 32'd2);
        // Load + reg_store, three memory wait cycles
        add(FR,      16'h0, RL_, 1'b0, 16'h0002, 32'd2);
        add(LD | RS, 16'h0, AL_, 1'b0, 16'h0002, 32'd2);
        add(MR,      16'h0, MF_, 1'b0, 16'h0002, 32'd2);
        add(NO,      16'h0, MF_, 1'b0, 16'h0002, 32'd2);
        add(NO,      16'h0, MF_, 1'b0, 16'h0002, 32'd2);
        add(NO,      16'h0, MF_, 1'b0, 16'h0002, 32'd2);
        add(MR,      16'h0, RS_, 1'b0, 16'h0002, 32'd2);
        add(NO,      16'h0, NX_, 1'b0, 16'h0002, 32'd2);
        add(NO,      16'h0, F_,  1'b0, 16'h0003, 32'd3);
        // Read-modify-write
        add(FR,           16'h0, RL_, 1'b0, 16'h0003, 32'd3);
        add(LD | ST | RS, 16'h0, AL_, 1'b0, 16'h0003, 32'd3);
        add(NO,           16'h0, MF_, 1'b0, 16'h0003, 32'd3);
        add(MR,           16'h0, MS_, 1'b0, 16'h0003, 32'd3);
        add(MR,           16'h0, RS_, 1'b0, 16'h0003, 32'd3);
        add(NO,           16'h0, NX_, 1'b0, 16'h0003, 32'd3);
        add(NO,           16'h0, F_,  1'b0, 16'h0004, 32'd4);
        // Store only, one wait
        add(FR, 16'h0, RL_, 1'b0, 16'h0004, 32'd4);
        add(ST, 16'h0, AL_, 1'b0, 16'h0004, 32'd4);
        add(NO, 16'h0, MS_, 1'b0, 16'h0004, 32'd4);
        add(NO, 16'h0, MS_, 1'b0, 16'h0004, 32'd4);
        add(MR, 16'h0, NX_, 1'b0, 16'h0004, 32'd4);
        add(NO, 16'h0, F_,  1'b0, 16'h0005, 32'd5);
        // Register store only
        add(FR, 16'h0, RL_, 1'b0, 16'h0005, 32'd5);
        add(RS, 16'h0, AL_, 1'b0, 16'h0005, 32'd5);
        add(NO, 16'h0, RS_, 1'b0, 16'h0005, 32'd5);
        add(NO, 16'h0, NX_, 1'b0, 16'h0005, 32'd5);
        add(NO, 16'h0, F_,  1'b0, 16'h0006, 32'd6);
        // Absolute jump to 0x0010, relative -4, absolute 0xBEEF, absolute 0xFFFF
        add(FR,      16'h0,    RL_, 1'b0, 16'h0006, 32'd6);
        add(NO,      16'h0,    AL_, 1'b0, 16'h0006, 32'd6);
        add(BT | BA, 16'h0010, NX_, 1'b0, 16'h0006, 32'd6);
        add(NO,      16'h0,    F_,  1'b0, 16'h0010, 32'd7);
        add(FR,      16'h0,    RL_, 1'b0, 16'h0010, 32'd7);
        add(NO,      16'h0,    AL_, 1'b0, 16'h0010, 32'd7);
        add(BT,      16'hFFFC, NX_, 1'b0, 16'h0010, 32'd7);
        add(NO,      16'h0,    F_,  1'b0, 16'h000C, 32'd8);
        add(FR,      16'h0,    RL_, 1'b0, 16'h000C, 32'd8);
        add(NO,      16'h0,    AL_, 1'b0, 16'h000C, 32'd8);
        add(BT | BA, 16'hBEEF, NX_, 1'b0, 16'h000C, 32'd8);
        add(NO,      16'h0,    F_,  1'b0, 16'hBEEF, 32'd9);
        add(FR,      16'h0,    RL_, 1'b0, 16'hBEEF, 32'd9);
        add(NO,      16'h0,    AL_, 1'b0, 16'hBEEF, 32'd9);
        add(BT | BA, 16'hFFFF, NX_, 1'b0, 16'hBEEF, 32'd9);
        add(NO,      16'h0,    F_,  1'b0, 16'hFFFF, 32'd10);
        // Sequential wrap; branch and decode inputs outside their states are ignored
        add(FR | BT | BA, 16'h1234, RL_, 1'b0, 16'hFFFF, 32'd10);
        add(NO,           16'h0,    AL_, 1'b0, 16'hFFFF, 32'd10);
        add(LD | HL,      16'h0,    NX_, 1'b0, 16'hFFFF, 32'd10);
        add(NO,           16'h0,    F_,  1'b0, 16'h0000, 32'd11);
        // HALT, hold 20 cycles, resume
        add(FR, 16'h0, RL_,   1'b0, 16'h0000, 32'd11);
        add(HL, 16'h0, AL_,   1'b0, 16'h0000, 32'd11);
        add(NO, 16'h0, NX_,   1'b0, 16'h0000, 32'd11);
        add(NO, 16'h0, NONE_, 1'b1, 16'h0001, 32'd12);
        for (int k = 0; k < 20; k++) add(FR | MR, 16'h0, NONE_, 1'b1, 16'h0001, 32'd12);
        add(RUN, 16'h0, F_, 1'b0, 16'h0001, 32'd12);
        // Halt again; reset wins over run
        add(FR,      16'h0, RL_,   1'b0, 16'h0001, 32'd12);
        add(HL,      16'h0, AL_,   1'b0, 16'h0001, 32'd12);
        add(NO,      16'h0, NX_,   1'b0, 16'h0001, 32'd12);
        add(NO,      16'h0, NONE_, 1'b1, 16'h0002, 32'd13);
        add(R | RUN, 16'h0, F_,    1'b0, 16'h0000, 32'd0);
        // Reset mid MEM_STORE with mem_ready low, then a clean instruction
        add(FR, 16'h0, RL_, 1'b0, 16'h0000, 32'd0);
        add(ST, 16'h0, AL_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, MS_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, MS_, 1'b0, 16'h0000, 32'd0);
        add(R,  16'h0, F_,  1'b0, 16'h0000, 32'd0);
        add(FR, 16'h0, RL_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, AL_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, NX_, 1'b0, 16'h0000, 32'd0);
        add(NO, 16'h0, F_,  1'b0, 16'h0001, 32'd1);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].flags, vecs[i].tgt);
            @(posedge clk); #1;
            chk($sformatf("v%0d_strobes", i), {25'd0, strobes()}, {25'd0, vecs[i].exp_strb});
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halt});
            chk($sformatf("v%0d_pc", i), {16'd0, pc}, {16'd0, vecs[i].exp_pc});
            chk($sformatf("v%0d_cnt", i), retired_count, vecs[i].exp_cnt);
        end
        drive(NO, 16'h0);

        // Multi-cycle latency sequences from pc=1, count=1
        run_instr(1'b0, 1'b0, 1'b0, 0, 16'h0002, 32'd2);
        run_instr(1'b1, 1'b0, 1'b1, 2, 16'h0003, 32'd3);
        run_instr(1'b1, 1'b1, 1'b1, 1, 16'h0004, 32'd4);
        run_instr(1'b0, 1'b1, 1'b0, 3, 16'h0005, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
